// File: rtl/ksa_shuffle_fsm.sv
// ksa_shuffle_fsm: ARC4 key-scheduling shuffle; swaps s[i] and s[j] over a 256x8 single-port RAM.
module ksa_shuffle_fsm #(
  parameter int KEY_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  input  logic [7:0]              q,
  output logic [7:0]              address,
  output logic [7:0]              write_data,
  output logic                    write_enable,
  output logic                    finish
);
  localparam int KW = KEY_LENGTH > 1 ? $clog2(KEY_LENGTH) : 1;
  typedef enum logic [3:0] {
    IDLE, RD_SI, WAIT_SI, CAP_SI, RD_SJ, WAIT_SJ, CAP_SJ, WR_SI, WR_SJ, NEXT, DONE
  } state_t;
  state_t state, state_n;
  logic [7:0] i, j, si, sj, key_byte;
  logic [KW-1:0] kidx;
  assign key_byte = secret_key[8*(KEY_LENGTH-int'(kidx))-1 -: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RD_SI : IDLE;
      RD_SI:   state_n = WAIT_SI;
      WAIT_SI: state_n = CAP_SI;
      CAP_SI:  state_n = RD_SJ;
      RD_SJ:   state_n = WAIT_SJ;
      WAIT_SJ: state_n = CAP_SJ;
      CAP_SJ:  state_n = WR_SI;
      WR_SI:   state_n = WR_SJ;
      WR_SJ:   state_n = NEXT;
      NEXT:    state_n = i == 8'hff ? DONE : RD_SI;
      default: state_n = IDLE;
    endcase
  end
  // Address and write port are decoded from state so reset clears them in the same cycle.
  always_comb begin
    address      = state inside {RD_SI, WAIT_SI, WR_SI} ? i :
                   state inside {RD_SJ, WAIT_SJ, WR_SJ} ? j : 8'd0;
    write_data   = state == WR_SI ? sj : state == WR_SJ ? si : 8'd0;
    write_enable = state inside {WR_SI, WR_SJ};
    finish       = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      i    <= 8'd0;
      j    <= 8'd0;
      si   <= 8'd0;
      sj   <= 8'd0;
      kidx <= '0;
    end else begin
      if (state == IDLE && start) begin
        i    <= 8'd0;
        j    <= 8'd0;
        kidx <= '0;
      end
      if (state == CAP_SI) begin
        si <= q;
        j  <= j + q + key_byte;
      end
      if (state == CAP_SJ) sj <= q;
      if (state == NEXT && i != 8'hff) begin
        i    <= i + 8'd1;
        kidx <= kidx == KW'(KEY_LENGTH-1) ? '0 : kidx + 1'b1;
      end
    end
endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// tb_ksa_shuffle_fsm: randomized self-checking bench against a software KSA model, KEY_LENGTH 3 and 1.
module tb_ksa_shuffle_fsm;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic        start1 = 0, we1, fin1;
  logic [23:0] key1 = 0;
  logic [7:0]  q1, a1, d1;
  logic        start2 = 0, we2, fin2;
  logic [7:0]  key2 = 0;
  logic [7:0]  q2, a2, d2;
  logic [7:0]  mem1 [256], mem2 [256], ld_val [256], es [256];
  logic        ld = 0;
  logic [15:0] wl1 [$], wl2 [$], ew [$];
  int n_checks = 0, n_fail = 0;

  ksa_shuffle_fsm dut1 (.clk(clk), .reset(reset), .start(start1), .secret_key(key1), .q(q1),
    .address(a1), .write_data(d1), .write_enable(we1), .finish(fin1));
  ksa_shuffle_fsm #(.KEY_LENGTH(1)) dut2 (.clk(clk), .reset(reset), .start(start2), .secret_key(key2),
    .q(q2), .address(a2), .write_data(d2), .write_enable(we2), .finish(fin2));

  // Single-port synchronous RAMs plus write loggers; ld preloads both RAMs.
  always @(posedge clk) begin
    if (ld) for (int k = 0; k < 256; k++) begin
      mem1[k] <= ld_val[k];
      mem2[k] <= ld_val[k];
    end else begin
      if (we1) mem1[a1] <= d1;
      if (we2) mem2[a2] <= d2;
    end
    q1 <= mem1[a1];
    q2 <= mem2[a2];
    if (we1 && !reset) wl1.push_back({a1, d1});
    if (we2 && !reset) wl2.push_back({a2, d2});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish before", $time);
    $fatal(1);
  end

  task automatic load_identity();
    for (int k = 0; k < 256; k++) ld_val[k] = 8'(k);
    @(negedge clk); ld = 1;
    @(posedge clk); #1 ld = 0;
  endtask

  // Reference: textbook KSA over es[], also listing the expected (addr,data) write stream.
  task automatic model(input int len, input logic [23:0] key);
    logic [7:0] j, t, kb;
    j = 0;
    ew.delete();
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (len - 1 - (i % len))));
      j = j + es[i] + kb;
      ew.push_back({8'(i), es[j]});
      ew.push_back({j, es[i]});
      t = es[i]; es[i] = es[j]; es[j] = t;
    end
  endtask

  task automatic do_run(input bit sel, input int pulse_at, input bit hold_done,
                        output int edges, output int width, output int wbase);
    wbase = sel ? wl2.size() : wl1.size();
    edges = 0;
    width = 0;
    @(negedge clk);
    if (sel) start2 = 1; else start1 = 1;
    @(posedge clk); #1;
    start1 = 0; start2 = 0;
    for (int n = 1; n <= 3000 && edges == 0; n++) begin
      @(posedge clk); #1;
      if (sel) start2 = 1'(n == pulse_at); else start1 = 1'(n == pulse_at);
      if (sel ? fin2 : fin1) begin
        edges = n;
        width = 1;
        if (hold_done) begin
          if (sel) start2 = 1; else start1 = 1;
        end
      end
    end
    @(posedge clk); #1;
    start1 = 0; start2 = 0;
    if (sel ? fin2 : fin1) width++;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks += 4;
    if (a1 !== 8'd0) begin n_fail++; $display("FAIL rst_addr: got %h required 00", a1); end
    if (d1 !== 8'd0) begin n_fail++; $display("FAIL rst_wdata: got %h required 00", d1); end
    if (we1 !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b required 0", we1); end
    if (fin1 !== 1'b0) begin n_fail++; $display("FAIL rst_finish: got %b required 0", fin1); end
    reset = 0;
    repeat (20) @(negedge clk);
    n_checks += 3;
    if (wl1.size() !== 0) begin n_fail++; $display("FAIL idle_writes: got %0d required 0", wl1.size()); end
    if (a1 !== 8'd0) begin n_fail++; $display("FAIL idle_addr: got %h required 00", a1); end
    if (fin1 !== 1'b0) begin n_fail++; $display("FAIL idle_finish: got %b required 0", fin1); end
  endtask

  task automatic test_first_iters();
    logic [15:0] tbl [6];
    int e, w, b, bad;
    tbl = '{16'h0000, 16'h0000, 16'h0103, 16'h0301, 16'h024e, 16'h4e02};
    load_identity();
    key1 = 24'h000249;
    for (int k = 0; k < 256; k++) es[k] = mem1[k];
    model(3, key1);
    do_run(0, 0, 0, e, w, b);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (wl1[b+k] !== tbl[k]) begin
        n_fail++; $display("FAIL first_wr%0d: got %h required %h", k, wl1[b+k], tbl[k]);
      end
    end
    n_checks += 3;
    if (e !== 2304) begin n_fail++; $display("FAIL fi_latency: got %0d required 2304", e); end
    if (w !== 1) begin n_fail++; $display("FAIL fi_finish_width: got %0d required 1", w); end
    if (wl1.size() - b !== 512) begin n_fail++; $display("FAIL fi_wcount: got %0d required 512", wl1.size() - b); end
    bad = 0;
    for (int k = 0; k < 512; k++) if (wl1[b+k] !== ew[k]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL fi_wr_seq: %0d writes differ, required 0", bad); end
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (mem1[k] !== es[k]) begin n_fail++; $display("FAIL fi_mem[%0d]: got %h required %h", k, mem1[k], es[k]); end
    end
  endtask

  task automatic test_full_ff();
    int e, w, b, bad;
    load_identity();
    key1 = 24'hffffff;
    for (int k = 0; k < 256; k++) es[k] = mem1[k];
    model(3, key1);
    do_run(0, 0, 0, e, w, b);
    n_checks += 2;
    if (e !== 2304) begin n_fail++; $display("FAIL ff_latency: got %0d required 2304", e); end
    if (wl1.size() - b !== 512) begin n_fail++; $display("FAIL ff_wcount: got %0d required 512", wl1.size() - b); end
    bad = 0;
    for (int k = 0; k < 512; k++) if (wl1[b+k] !== ew[k]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL ff_wr_seq: %0d writes differ, required 0", bad); end
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (mem1[k] !== es[k]) begin n_fail++; $display("FAIL ff_mem[%0d]: got %h required %h", k, mem1[k], es[k]); end
    end
  endtask

  task automatic test_overlap();
    int e, w, b;
    load_identity();
    key1 = 24'($urandom);
    for (int k = 0; k < 256; k++) es[k] = mem1[k];
    model(3, key1);
    do_run(0, 1000 + int'($urandom_range(0, 900)), 1, e, w, b);
    n_checks += 3;
    if (e !== 2304) begin n_fail++; $display("FAIL ov_latency: got %0d required 2304", e); end
    if (w !== 1) begin n_fail++; $display("FAIL ov_finish_width: got %0d required 1", w); end
    if (wl1.size() - b !== 512) begin n_fail++; $display("FAIL ov_wcount: got %0d required 512", wl1.size() - b); end
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (mem1[k] !== es[k]) begin n_fail++; $display("FAIL ov_mem[%0d]: got %h required %h", k, mem1[k], es[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int e, w, b, bad;
    for (int k = 0; k < 256; k++) es[k] = mem1[k];
    model(3, key1);
    do_run(0, 0, 0, e, w, b);
    n_checks += 3;
    if (e !== 2304) begin n_fail++; $display("FAIL b2b_latency: got %0d required 2304", e); end
    if (wl1[b] !== ew[0]) begin n_fail++; $display("FAIL b2b_first_wr: got %h required %h", wl1[b], ew[0]); end
    if (wl1.size() - b !== 512) begin n_fail++; $display("FAIL b2b_wcount: got %0d required 512", wl1.size() - b); end
    bad = 0;
    for (int k = 0; k < 512; k++) if (wl1[b+k] !== ew[k]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_wr_seq: %0d writes differ, required 0", bad); end
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (mem1[k] !== es[k]) begin n_fail++; $display("FAIL b2b_mem[%0d]: got %h required %h", k, mem1[k], es[k]); end
    end
  endtask

  task automatic test_reset_midrun();
    int b, cnt, guard;
    load_identity();
    key1 = 24'($urandom);
    for (int k = 0; k < 256; k++) es[k] = mem1[k];
    model(3, key1);
    b = wl1.size();
    cnt = 0;
    guard = 0;
    @(negedge clk); start1 = 1;
    @(negedge clk); start1 = 0;
    while (cnt < 76 && guard < 1000) begin
      if (we1) cnt++;
      if (cnt < 76) @(negedge clk);
      guard++;
    end
    n_checks += 3;
    if (cnt !== 76) begin n_fail++; $display("FAIL mr_reach: got %0d writes required 76", cnt); end
    if (a1 !== ew[75][15:8]) begin n_fail++; $display("FAIL mr_wrsj_addr: got %h required %h", a1, ew[75][15:8]); end
    if (d1 !== ew[75][7:0]) begin n_fail++; $display("FAIL mr_wrsj_data: got %h required %h", d1, ew[75][7:0]); end
    reset = 1;
    #1;
    n_checks += 3;
    if (we1 !== 1'b0) begin n_fail++; $display("FAIL mr_we: got %b required 0", we1); end
    if (a1 !== 8'd0) begin n_fail++; $display("FAIL mr_addr: got %h required 00", a1); end
    if (fin1 !== 1'b0) begin n_fail++; $display("FAIL mr_finish: got %b required 0", fin1); end
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);
    n_checks += 2;
    if (wl1.size() - b !== 75) begin n_fail++; $display("FAIL mr_no_resume: got %0d writes required 75", wl1.size() - b); end
    if (a1 !== 8'd0) begin n_fail++; $display("FAIL mr_idle_addr: got %h required 00", a1); end
  endtask

  task automatic test_param();
    int e, w, b;
    load_identity();
    key2 = 8'h01;
    for (int k = 0; k < 256; k++) es[k] = mem2[k];
    model(1, {16'h0, key2});
    do_run(1, 0, 0, e, w, b);
    n_checks += 5;
    if (wl2[b] !== 16'h0001) begin n_fail++; $display("FAIL p_wr0: got %h required 0001", wl2[b]); end
    if (wl2[b+1] !== 16'h0100) begin n_fail++; $display("FAIL p_wr1: got %h required 0100", wl2[b+1]); end
    if (wl2[b+2] !== 16'h0102) begin n_fail++; $display("FAIL p_wr2: got %h required 0102", wl2[b+2]); end
    if (e !== 2304) begin n_fail++; $display("FAIL p_latency: got %0d required 2304", e); end
    if (wl2.size() - b !== 512) begin n_fail++; $display("FAIL p_wcount: got %0d required 512", wl2.size() - b); end
    for (int k = 0; k < 256; k++) begin
      n_checks++;
      if (mem2[k] !== es[k]) begin n_fail++; $display("FAIL p_mem[%0d]: got %h required %h", k, mem2[k], es[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_iters();
    test_full_ff();
    test_overlap();
    test_back_to_back();
    test_reset_midrun();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
